// File: rtl/dma_axi_w_feeder_pkg.sv
// Shared types and constants for the AXI write-burst feeder.
package dma_axi_w_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SIZE      = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_BURST     = 3'd3,
        ST_WAIT_RESP = 3'd4
    } state_t;

    localparam int unsigned BOUNDARY_4K = 4096;

    function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/dma_axi_w_feeder_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on o_data while not empty.
module dma_w_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_level,
    output logic             o_full,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_mem [2**AW];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(2**AW));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rptr];
    assign o_level = r_level;

    // Storage carries no reset so it can map onto RAM.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dma_axi_w_feeder.sv
// Splits a transfer into 4KB-safe INCR bursts and feeds the AXI write engine,
// launching a burst only once all of its beats are buffered.
module dma_axi_w_feeder
    import dma_axi_w_feeder_pkg::*;
#(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int ADDR_W         = 32,
    parameter int LEN_W          = 8,
    parameter int TLEN_W         = 24,
    parameter int FIFO_AW        = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [ADDR_W-1:0]           i_cfg_addr,
    input  logic [TLEN_W-1:0]           i_cfg_len,
    input  logic                        i_cfg_start,
    output logic                        o_busy,
    output logic                        o_done,
    input  logic [DMA_DATA_WIDTH-1:0]   i_s_data,
    input  logic                        i_s_valid,
    output logic                        o_s_ready,
    output logic [FIFO_AW:0]            o_level,
    output logic                        o_valid,
    output logic [ADDR_W-1:0]           o_addr,
    output logic [DMA_DATA_WIDTH-1:0]   o_wdata,
    output logic [DMA_DATA_WIDTH/8-1:0] o_wstrb,
    input  logic                        i_ready,
    output logic [LEN_W-1:0]            o_dma_len,
    input  logic                        i_dma_ready
);
    // state        | meaning
    // ST_IDLE      | waiting for cfg_start; stream still prefetched
    // ST_SIZE      | compute next burst length
    // ST_WAIT_DATA | wait for whole burst buffered and engine idle
    // ST_BURST     | valid high, one word popped per ready
    // ST_WAIT_RESP | wait for engine to return to address phase
    localparam int BYTES  = DMA_DATA_WIDTH / 8;
    localparam int BSH    = $clog2(BYTES);
    localparam int BEAT_W = LEN_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BYTES - 1));

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [TLEN_W-1:0]   r_remaining;
    logic [BEAT_W-1:0]   r_beats;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_dma_len;
    logic                r_busy;
    logic                r_done;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_launch;
    logic [12:0]         w_to_bound_bytes;
    logic [12:0]         w_to_bound_words;
    logic [31:0]         w_beats_calc;

    assign w_push    = i_s_valid && !w_full;
    assign w_pop     = (r_state == ST_BURST) && r_valid && i_ready;
    assign o_s_ready = !w_full;

    dma_w_fifo #(
        .WIDTH (DMA_DATA_WIDTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_s_data),
        .i_pop   (w_pop),
        .o_data  (o_wdata),
        .o_level (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Distance to the next 4KB page is 1..4096 bytes since cur_addr is word aligned.
    assign w_to_bound_bytes = 13'(BOUNDARY_4K) - {1'b0, r_cur_addr[11:0]};
    assign w_to_bound_words = w_to_bound_bytes >> BSH;
    assign w_beats_calc     = min3(32'(r_remaining), 32'd1 << LEN_W, 32'(w_to_bound_words));
    assign w_launch         = i_dma_ready && (32'(o_level) >= 32'(r_beats));

    assign o_valid   = r_valid;
    assign o_addr    = r_addr;
    assign o_dma_len = r_dma_len;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_wstrb   = {BYTES{r_valid}};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_beats     <= '0;
            r_beat_cnt  <= '0;
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_dma_len   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_start) begin
                        r_cur_addr  <= i_cfg_addr & ALIGN_MASK;
                        r_remaining <= i_cfg_len;
                        if (i_cfg_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= ST_SIZE;
                        end
                    end
                end
                ST_SIZE: begin
                    r_beats   <= BEAT_W'(w_beats_calc);
                    r_dma_len <= LEN_W'(w_beats_calc - 32'd1);
                    r_state   <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (w_launch) begin
                        r_valid    <= 1'b1;
                        r_addr     <= r_cur_addr;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_pop) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        if (r_beat_cnt == r_beats - BEAT_W'(1)) begin
                            r_valid     <= 1'b0;
                            r_cur_addr  <= r_cur_addr + (ADDR_W'(r_beats) << BSH);
                            r_remaining <= r_remaining - TLEN_W'(r_beats);
                            r_state     <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (i_dma_ready) begin
                        if (r_remaining == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_SIZE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_axi_w_feeder.sv
// Scoreboard bench for dma_axi_w_feeder with a behavioural write-engine model.
module tb_dma_axi_w_feeder;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int LW  = 8;
    localparam int TW  = 24;
    localparam int FAW = 8;

    logic            clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [AW-1:0]   i_cfg_addr = '0;
    logic [TW-1:0]   i_cfg_len = '0;
    logic            i_cfg_start = 1'b0;
    logic            o_busy, o_done;
    logic [DW-1:0]   i_s_data = '0;
    logic            i_s_valid = 1'b0;
    logic            o_s_ready;
    logic [FAW:0]    o_level;
    logic            o_valid;
    logic [AW-1:0]   o_addr;
    logic [DW-1:0]   o_wdata;
    logic [DW/8-1:0] o_wstrb;
    logic            i_ready = 1'b0;
    logic [LW-1:0]   o_dma_len;
    logic            i_dma_ready = 1'b1;

    always #5 clk = ~clk;

    dma_axi_w_feeder #(
        .DMA_DATA_WIDTH (DW), .ADDR_W (AW), .LEN_W (LW), .TLEN_W (TW), .FIFO_AW (FAW)
    ) dut (
        .i_clk (clk), .i_rst (i_rst),
        .i_cfg_addr (i_cfg_addr), .i_cfg_len (i_cfg_len), .i_cfg_start (i_cfg_start),
        .o_busy (o_busy), .o_done (o_done),
        .i_s_data (i_s_data), .i_s_valid (i_s_valid), .o_s_ready (o_s_ready),
        .o_level (o_level),
        .o_valid (o_valid), .o_addr (o_addr), .o_wdata (o_wdata), .o_wstrb (o_wstrb),
        .i_ready (i_ready), .o_dma_len (o_dma_len), .i_dma_ready (i_dma_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Written by the main sequence only
    logic [AW-1:0] exp_baddr [$];
    logic [LW-1:0] exp_blen  [$];
    int feed_total = 0;
    int feed_gap   = 0;

    // Written by the stream/engine model only
    logic [DW-1:0] exp_data [$];
    typedef enum {E_IDLE, E_DATA, E_RESP} eng_t;
    eng_t e_st = E_IDLE;
    int b_rd = 0, beats_left = 0, resp_wait = 0;
    int pops_total = 0, bursts_total = 0, done_cnt = 0;
    int fed = 0, gap_cnt = 0;
    bit s_hold = 1'b0;

    always @(negedge clk) begin
        if (i_rst) begin
            e_st        = E_IDLE;
            i_ready     = 1'b0;
            i_dma_ready = 1'b1;
            i_s_valid   = 1'b0;
            s_hold      = 1'b0;
            gap_cnt     = 0;
            exp_data.delete();
            b_rd        = exp_baddr.size();
        end else begin
            if (o_done) done_cnt++;
            // stream source: a word offered now is taken at the next edge iff s_ready
            if (fed < feed_total && gap_cnt == 0) begin
                if (!s_hold) i_s_data = $urandom;
                i_s_valid = 1'b1;
                if (o_s_ready) begin
                    exp_data.push_back(i_s_data);
                    fed++;
                    gap_cnt = feed_gap;
                    s_hold  = 1'b0;
                end else begin
                    s_hold = 1'b1;
                end
            end else begin
                i_s_valid = 1'b0;
                if (gap_cnt > 0) gap_cnt--;
            end
            case (e_st)
                E_IDLE: begin
                    i_dma_ready = 1'b1;
                    if (o_valid) begin
                        bursts_total++;
                        if (b_rd < exp_baddr.size()) begin
                            chk("burst_addr", o_addr, exp_baddr[b_rd]);
                            chk("burst_len", o_dma_len, exp_blen[b_rd]);
                            chk("launch_level", 64'(32'(o_level) >= 32'(o_dma_len) + 1), 1);
                            b_rd++;
                        end else begin
                            chk("stray_valid", o_valid, 0);
                        end
                        chk("wstrb_on", o_wstrb, 4'hF);
                        beats_left  = int'(o_dma_len) + 1;
                        i_dma_ready = 1'b0;
                        e_st        = E_DATA;
                    end
                end
                E_RESP: begin
                    chk("valid_low", o_valid, 0);
                    if (resp_wait == 0) begin
                        i_dma_ready = 1'b1;
                        e_st        = E_IDLE;
                    end else begin
                        resp_wait--;
                    end
                end
                default: ;
            endcase
            if (e_st == E_DATA) begin
                if (beats_left == 0) begin
                    i_ready   = 1'b0;
                    chk("valid_drop", o_valid, 0);
                    resp_wait = $urandom_range(0, 3);
                    e_st      = E_RESP;
                end else begin
                    chk("valid_held", o_valid, 1);
                    i_ready = ($urandom_range(0, 3) != 0);
                    if (i_ready) begin
                        chk("nonempty", 64'(o_level != 0), 1);
                        if (exp_data.size() == 0) chk("data_avail", 0, 1);
                        else chk("wdata", o_wdata, exp_data.pop_front());
                        beats_left--;
                        pops_total++;
                    end
                end
            end
        end
    end

    task automatic wait_level(input int n);
        int k = 0;
        while (int'(o_level) < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("level_reached", 64'(int'(o_level) >= n), 1);
    endtask

    task automatic push_burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
        exp_baddr.push_back(a);
        exp_blen.push_back(l);
    endtask

    task automatic xfer(input logic [AW-1:0] a, input int len, input int nb, input int np);
        int d0, b0, p0, k;
        d0 = done_cnt; b0 = bursts_total; p0 = pops_total; k = 0;
        i_cfg_addr  = a;
        i_cfg_len   = TW'(len);
        i_cfg_start = 1'b1;
        @(negedge clk);
        i_cfg_start = 1'b0;
        chk("busy_after_start", o_busy, 64'(len != 0));
        if (len == 0) chk("done_immediate", o_done, 1);
        while (done_cnt == d0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 64'(done_cnt != d0), 1);
        repeat (4) @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
        chk("busy_idle", o_busy, 0);
        chk("bursts", bursts_total - b0, nb);
        chk("pops", pops_total - p0, np);
        chk("sb_empty", exp_data.size(), 0);
    endtask

    initial begin
        int p0, k;
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_len", o_dma_len, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_wstrb", o_wstrb, 0);
        chk("rst_level", o_level, 0);
        chk("rst_sready", o_s_ready, 1);
        i_rst = 1'b0;
        @(negedge clk);

        // single short burst, data preloaded
        feed_total += 4;
        wait_level(4);
        push_burst(32'h1000, 8'd3);
        xfer(32'h1000, 4, 1, 4);

        // long transfer split at 256 beats, data streamed
        feed_total += 300;
        push_burst(32'h0, 8'd255);
        push_burst(32'h400, 8'd43);
        xfer(32'h0, 300, 2, 300);

        // unaligned start near a 4KB page end
        feed_total += 8;
        wait_level(8);
        push_burst(32'hFF0, 8'd3);
        push_burst(32'h1000, 8'd3);
        xfer(32'hFF3, 8, 2, 8);

        // empty buffer at start, slow trickle
        feed_gap = 3;
        feed_total += 16;
        push_burst(32'h2000, 8'd15);
        xfer(32'h2000, 16, 1, 16);
        feed_gap = 0;

        // zero-length transfer
        xfer(32'h500, 0, 0, 0);

        // reset in the middle of a burst
        feed_total += 16;
        wait_level(16);
        push_burst(32'h3000, 8'd15);
        p0 = pops_total;
        i_cfg_addr  = 32'h3000;
        i_cfg_len   = 24'd16;
        i_cfg_start = 1'b1;
        @(negedge clk);
        i_cfg_start = 1'b0;
        k = 0;
        while (pops_total < p0 + 5 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("mid_burst_reached", 64'(pops_total >= p0 + 5), 1);
        i_rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", o_valid, 0);
        chk("rst_mid_level", o_level, 0);
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_sready", o_s_ready, 1);
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);

        feed_total += 4;
        wait_level(4);
        push_burst(32'h44, 8'd3);
        xfer(32'h46, 4, 1, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
